// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin, packet-locked scheduler sharing one UART transmitter among NUM_REQ byte streams
module uart_tx_sched #(
    parameter int NUM_REQ     = 4,
    parameter int ACK_TIMEOUT = 15,
    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int CW = $clog2(ACK_TIMEOUT + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [7:0]           tx_data,
    output logic                 tx_start,
    input  logic                 tx_busy,
    output logic [GW-1:0]        grant_id,
    output logic                 sched_busy,
    output logic                 err_timeout,
    input  logic                 err_clear
);
    typedef enum logic [2:0] {IDLE, SEL, START, WAIT_ACK, WAIT_DONE} state_t;

    state_t        state_q, state_d;
    logic [GW-1:0] grant_q, grant_d, last_grant_q, last_grant_d, win, idx;
    logic          locked_q, locked_d, last_flag_q, last_flag_d;
    logic          tx_start_q, tx_start_d, sched_busy_q, sched_busy_d, err_q, err_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          accept, timeout, grant_start, pkt_end;

    assign accept      = (state_q == SEL) && req_valid[grant_q];
    assign timeout     = (state_q == WAIT_ACK) && !tx_busy && (cnt_q == CW'(ACK_TIMEOUT - 1));
    assign grant_start = (state_q == IDLE) && (|req_valid) && !locked_q;
    assign pkt_end     = timeout || ((state_q == WAIT_DONE) && !tx_busy && last_flag_q);

    assign req_ready   = (state_q == SEL) ? (req_valid & (NUM_REQ'(1) << grant_q)) : '0;
    assign tx_data     = tx_data_q;
    assign tx_start    = tx_start_q;
    assign grant_id    = grant_q;
    assign sched_busy  = sched_busy_q;
    assign err_timeout = err_q;

    // State and datapath registers; asynchronous active-low reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= GW'(NUM_REQ - 1);
            locked_q     <= 1'b0;
            last_flag_q  <= 1'b0;
            tx_data_q    <= '0;
            tx_start_q   <= 1'b0;
            sched_busy_q <= 1'b0;
            err_q        <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            locked_q     <= locked_d;
            last_flag_q  <= last_flag_d;
            tx_data_q    <= tx_data_d;
            tx_start_q   <= tx_start_d;
            sched_busy_q <= sched_busy_d;
            err_q        <= err_d;
            cnt_q        <= cnt_d;
        end
    end

    // Round-robin winner: scan downward so the nearest requester after last_grant is kept
    always_comb begin
        win = last_grant_q;
        idx = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            idx = GW'((int'(last_grant_q) + i) % NUM_REQ);
            if (req_valid[idx]) win = idx;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      state_d = grant_start ? SEL : IDLE;
            SEL:       state_d = accept ? START : SEL;
            START:     state_d = WAIT_ACK;
            WAIT_ACK:  state_d = tx_busy ? WAIT_DONE : (timeout ? IDLE : WAIT_ACK);
            WAIT_DONE: state_d = tx_busy ? WAIT_DONE : (last_flag_q ? IDLE : SEL);
            default:   state_d = IDLE;
        endcase
    end

    // Registered outputs and bookkeeping; timeout set beats err_clear
    always_comb begin
        grant_d      = grant_start ? win : grant_q;
        locked_d     = grant_start | (locked_q & ~pkt_end);
        last_grant_d = pkt_end ? grant_q : last_grant_q;
        tx_data_d    = accept ? req_data[{grant_q, 3'b000} +: 8] : tx_data_q;
        last_flag_d  = accept ? req_last[grant_q] : last_flag_q;
        tx_start_d   = accept;
        cnt_d        = (state_q == START) ? '0 : ((state_q == WAIT_ACK) && !tx_busy) ? cnt_q + CW'(1) : cnt_q;
        err_d        = timeout | (err_q & ~err_clear);
        sched_busy_d = (state_d != IDLE);
    end
endmodule

// File: doc/uart_tx_sched.md
# uart_tx_sched

Round-robin scheduler that shares one UART transmitter among `NUM_REQ` byte-stream requesters. It sits between client blocks, such as status reporters and debug dumpers, and the transmitter, which has an 8-bit `data_in`, a `tx_start` strobe and a `tx_busy` status. It grants one requester at a time and holds the grant for a whole packet, which ends at `req_last`. It sequences each byte through the transmitter's start/busy handshake and flags a transmitter that never acknowledges a start.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `ACK_TIMEOUT`, default 15: maximum cycles to wait for `tx_busy` to rise after `tx_start`.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  NUM_REQ  per-requester byte available.
- `req_data`  in  8*NUM_REQ  per-requester byte; requester i uses bits [8i+7:8i].
- `req_last`  in  NUM_REQ  byte is the final byte of the requester's packet.
- `req_ready`  out  NUM_REQ  one-hot byte-accept strobe.
- `tx_data`  out  8  byte presented to the transmitter's `data_in`.
- `tx_start`  out  1  one-cycle start strobe to the transmitter.
- `tx_busy`  in  1  transmitter busy; it rises some cycles after `tx_start` and falls after the stop bit.
- `grant_id`  out  clog2(NUM_REQ)  index of the current or last granted requester.
- `sched_busy`  out  1  high in every state except IDLE.
- `err_timeout`  out  1  sticky; set when `tx_busy` fails to rise within `ACK_TIMEOUT`.
- `err_clear`  in  1  synchronous clear of `err_timeout`.

## Operation
- States: IDLE, SEL, START, WAIT_ACK, WAIT_DONE.
- **IDLE**
  - If any `req_valid` is high, pick the winner round-robin: the first requester with `req_valid` high, searching upward from `last_grant+1` mod `NUM_REQ`.
  - Register the winner into `grant_id`, set `locked`=1 and go to SEL.
- **SEL**
  - `req_ready[grant_id]` = `req_valid[grant_id]`, asserted for exactly one cycle.
  - On acceptance: latch `req_data[grant_id]` into `tx_data`, latch `req_last` into `last_flag`, go to START.
  - If a locked requester drops `req_valid` mid-packet, stay in SEL with no timeout. No other requester may be granted while `locked`=1.
- **START**
  - Drive `tx_start`=1 for exactly one cycle and clear the ack counter.
  - Go to WAIT_ACK.
- **WAIT_ACK**
  - If `tx_busy`=1, go to WAIT_DONE.
  - Otherwise increment the ack counter. When the counter reaches `ACK_TIMEOUT`:
    - set `err_timeout`;
    - clear `locked`;
    - set `last_grant`=`grant_id`;
    - go to IDLE, dropping the rest of the packet from the scheduler's view. The requester is re-arbitrated normally.
- **WAIT_DONE**
  - Wait until `tx_busy`=0.
  - If `last_flag`=0, go to SEL with the same grant.
  - If `last_flag`=1: clear `locked`, set `last_grant`=`grant_id`, go to IDLE.
- `tx_data` is stable from the SEL acceptance edge until the next acceptance.
- `err_clear` and a simultaneous timeout: the set wins.
- `NUM_REQ`-1 wrap: the search after requester `NUM_REQ`-1 continues at 0.
- Non-granted requesters never see `req_ready` asserted.

## Timing
- Reset values:
  - state IDLE;
  - `req_ready`=0, `tx_start`=0, `tx_data`=0;
  - `grant_id`=0;
  - `sched_busy`=0, `err_timeout`=0;
  - `last_grant`=`NUM_REQ`-1, so requester 0 has first priority;
  - `locked`=0.
- Reset mid-transfer: everything returns to reset values immediately. The partially accepted packet is abandoned, and the transmitter finishes its frame independently.
- All outputs are registered, except `req_ready`, which is decoded from state, `grant_id` and `req_valid`.
- Latency: `req_valid` high at cycle 0 in IDLE gives:
  - SEL with `req_ready` at cycle 1;
  - `tx_start` at cycle 2;
  - earliest `tx_busy` sampled in WAIT_ACK at cycle 3.
- Byte-to-byte overhead within a packet: 3 cycles (SEL, START, WAIT_ACK) plus the transmitter's ack delay, after `tx_busy` falls.
- Timeout fires on the `ACK_TIMEOUT`-th consecutive WAIT_ACK cycle with `tx_busy`=0.

## Test plan
- **Single byte:** requester 2 sends 0xA5 with last=1.
  - Expect one `req_ready[2]` pulse, `tx_data`=0xA5, one `tx_start`.
  - Expect return to IDLE after `tx_busy` falls, `grant_id`=2.
- **Round-robin:** requesters 0 and 1 each hold a single-byte packet valid continuously.
  - Expect grants in the order 0,1,0,1.
  - Then with all four valid after `last_grant`=3, expect the order 0,1,2,3.
- **Packet lock:** requester 1 sends 0x11,0x22,0x33 (last on 0x33) while requester 0 is valid throughout.
  - Expect all three bytes to go to the transmitter before any `req_ready[0]`.
  - Insert a 5-cycle gap in `req_valid[1]` mid-packet; expect the grant to be held.
- **Ack timeout:** the transmitter model never raises `tx_busy`.
  - Expect `err_timeout`=1 exactly 15 cycles after WAIT_ACK entry, then IDLE.
  - Pulse `err_clear`; expect `err_timeout`=0.
- **Reset mid-operation:** assert `reset` during WAIT_DONE.
  - Expect all outputs at reset values on the same edge.
  - After release, requester 0 wins over requester 3 when both are valid.
- **Timeout and clear together:** `err_clear` coincides with timeout expiry; expect `err_timeout`=1.
